uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (8 data bits + parity, 14 clk_3125 cycles/bit) among NUM_REQ byte sources.
//  Round-robin arbitration; each granted byte goes out as a header frame (HDR_BASE|id), then a data frame.
//  Sits between the per-function byte producers and the shared uart_tx instance.
// PARAMETERS
//  NUM_REQ   4       number of requesters (id width 2, fixed at 4 in this revision)
//  HDR_EN    1       1: send header byte before data; 0: data byte only
//  HDR_BASE  8'hA0   header value; header = HDR_BASE | {6'b0, id}
//  TIMEOUT   512     max cycles waiting for tx_done per frame (one frame = 154 cycles)
// PORTS
//  clk_3125     in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  req          in   4   req[i]=1: requester i has a byte pending
//  req_data     in   32  requester i byte on [8i+7:8i]
//  ack          out  4   one-cycle pulse: requester i's byte latched
//  tx_start     out  1   one-cycle pulse to uart_tx: load tx_data, start frame
//  tx_data      out  8   byte to uart_tx; held stable from tx_start until tx_done
//  tx_done      in   1   one-cycle pulse from uart_tx at end of stop bit
//  grant_id     out  2   id of requester currently being served
//  busy         out  1   1 whenever state != IDLE
//  timeout_err  out  1   one-cycle pulse on tx_done timeout
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, ack=0, tx_start=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, timer=0.
//  Reset mid-frame aborts; no resume, no ack re-issue, latched byte dropped.
//  States: IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA.
//  IDLE: if req!=0, winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod 4.
//   On that edge: data_q<=req_data[winner], grant_id<=winner, ack[winner]<=1 (1 cycle),
//   busy<=1, state<=SEND_HDR (HDR_EN=1) or SEND_DATA (HDR_EN=0).
//  req is sampled only in IDLE; requester changes byte/drops req after ack; held req = new byte.
//  SEND_HDR: tx_start=1 for 1 cycle, tx_data=HDR_BASE|grant_id; -> WAIT_HDR, timer=0.
//  WAIT_HDR: tx_done=1 -> SEND_DATA; else timer++.
//  SEND_DATA: tx_start=1 for 1 cycle, tx_data=data_q; -> WAIT_DATA, timer=0.
//  WAIT_DATA: tx_done=1 -> IDLE, rr_ptr<=grant_id+1 (mod 4, wraps 3->0), busy<=0.
//  Timeout: in WAIT_* with timer==TIMEOUT-1 and no tx_done -> timeout_err pulse,
//   IDLE, rr_ptr<=grant_id+1; remaining frame of that transfer dropped.
//  tx_done and timeout on same cycle: tx_done wins, no error.
//  tx_done outside WAIT_* ignored. Min gap IDLE->next tx_start: 2 cycles (IDLE, SEND_*).
//  Latency req->first tx_start: 2 edges. ack and tx_start never asserted in same cycle.
//  timer 10 bits, saturates, cleared on every SEND_* entry.
// TESTING
//  1 req[1]=1, data 8'h5C, HDR_EN=1 -> ack[1] pulse; tx_data A1 then 5C, two tx_start; rr_ptr=2.
//  2 req=4'b0101 after reset -> req0 served first (A0,d0), then req2 (A2,d2); ack order 0,2.
//  3 req=4'b1111 held 8 transfers -> grant order 0,1,2,3,0,1,2,3; wraps 3->0.
//  4 tx_done never arrives after header -> timeout_err at TIMEOUT cycles after tx_start; IDLE; data not sent.
//  5 reset asserted in WAIT_DATA -> next edge: tx_start=0, busy=0, rr_ptr=0, no ack; then req0 served normally.
//  6 HDR_EN=0, req[3]=1, 8'hFF -> one tx_start, tx_data=FF; tx_done during IDLE ignored.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte sources.
// Each grant sends an optional header frame (HDR_BASE|id) followed by the data frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer; arbitrate among pending requests each cycle
// SEND_HDR  | pulse tx_start with the header byte for the granted id
// WAIT_HDR  | header frame on the line; wait for tx_done or timeout
// SEND_DATA | pulse tx_start with the latched data byte
// WAIT_DATA | data frame on the line; wait for tx_done or timeout
module uart_tx_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter bit          HDR_EN   = 1'b1,
    parameter logic [7:0]  HDR_BASE = 8'hA0,
    parameter int          TIMEOUT  = 512
) (
    input  logic                   clk_3125,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        WAIT_HDR  = 3'd2,
        SEND_DATA = 3'd3,
        WAIT_DATA = 3'd4
    } state_t;

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [7:0]  data_q;
    logic [9:0]  timer;

    logic        win_vld;
    logic [1:0]  win_id;
    logic [1:0]  scan_id;
    logic [7:0]  win_data;

    // Scan downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = rr_ptr;
        scan_id = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_id = rr_ptr + 2'(k);
            if (req[scan_id]) begin
                win_vld = 1'b1;
                win_id  = scan_id;
            end
        end
    end

    assign win_data = req_data[{win_id, 3'b000} +: 8];

    always_ff @(posedge clk_3125) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            data_q      <= 8'd0;
            timer       <= 10'd0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            grant_id    <= 2'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        data_q   <= win_data;
                        grant_id <= win_id;
                        ack      <= NUM_REQ'(1) << win_id;
                        busy     <= 1'b1;
                        state    <= HDR_EN ? SEND_HDR : SEND_DATA;
                    end
                end

                SEND_HDR: begin
                    tx_start <= 1'b1;
                    tx_data  <= HDR_BASE | {6'b0, grant_id};
                    timer    <= 10'd0;
                    state    <= WAIT_HDR;
                end

                WAIT_HDR: begin
                    if (tx_done) begin
                        state <= SEND_DATA;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= grant_id + 2'd1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (timer != 10'h3FF) begin
                        timer <= timer + 10'd1;
                    end
                end

                SEND_DATA: begin
                    tx_start <= 1'b1;
                    tx_data  <= data_q;
                    timer    <= 10'd0;
                    state    <= WAIT_DATA;
                end

                WAIT_DATA: begin
                    // tx_done takes priority over a coincident timeout
                    if (tx_done) begin
                        rr_ptr <= grant_id + 2'd1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= grant_id + 2'd1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (timer != 10'h3FF) begin
                        timer <= timer + 10'd1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level round-robin model plus a uart_tx responder.
// A second instance with HDR_EN=0 covers the data-only path.
module tb_uart_tx_arbiter;

    localparam int         TIMEOUT  = 512;
    localparam logic [7:0] HDR_BASE = 8'hA0;

    logic        clk_3125 = 1'b0;
    always #5 clk_3125 = ~clk_3125;

    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    logic [3:0]  req_n;
    logic [31:0] req_data_n;
    logic [3:0]  ack_n;
    logic        tx_start_n;
    logic [7:0]  tx_data_n;
    logic        tx_done_n;
    logic [1:0]  grant_id_n;
    logic        busy_n;
    logic        timeout_err_n;

    uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1'b1), .HDR_BASE(HDR_BASE), .TIMEOUT(TIMEOUT)) u_dut (
        .clk_3125(clk_3125), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1'b0), .HDR_BASE(HDR_BASE), .TIMEOUT(TIMEOUT)) u_dut_nh (
        .clk_3125(clk_3125), .reset(reset), .req(req_n), .req_data(req_data_n), .ack(ack_n),
        .tx_start(tx_start_n), .tx_data(tx_data_n), .tx_done(tx_done_n), .grant_id(grant_id_n),
        .busy(busy_n), .timeout_err(timeout_err_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int         model_rr = 0;
    logic [7:0] exp_q[$];
    int         ack_log[$];
    int         resp_cnt = -1;
    bit         resp_en = 1'b1;
    bit         rand_on = 1'b0;
    bit         spur_on = 1'b0;
    bit         expect_to = 1'b0;
    bit         to_seen = 1'b0;
    int         keep_mode = 0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    int         first_start_cyc = -1;
    logic [7:0] held_data = 8'd0;

    function automatic int pick(input logic [3:0] r, input int rr);
        for (int k = 0; k < 4; k++) begin
            if (r[(rr + k) % 4]) return (rr + k) % 4;
        end
        return 4;
    endfunction

    // One clock: drive responder, check outputs against the model, update requesters.
    task automatic cycle();
        int w;
        @(negedge clk_3125);
        cyc++;

        tx_done = 1'b0;
        if (resp_cnt == 0) begin
            chk_eq("tx_data_hold", tx_data, held_data);
            tx_done  = 1'b1;
            resp_cnt = -1;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
        end
        if (spur_on && !busy && resp_cnt < 0 && !tx_done && $urandom_range(0, 15) == 0)
            tx_done = 1'b1;

        if (ack != 4'd0) begin
            w = pick(req, model_rr);
            chk_eq("ack_onehot", $countones(ack), 1);
            chk_eq("ack_id", ack, (w < 4) ? (32'd1 << w) : 32'd0);
            chk_eq("ack_start_excl", tx_start, 0);
            chk_eq("ack_while_pending", exp_q.size(), 0);
            if (w < 4) begin
                chk_eq("grant_id", grant_id, w);
                exp_q.push_back(HDR_BASE | 8'(w));
                exp_q.push_back(req_data[8*w +: 8]);
                model_rr = (w + 1) % 4;
                ack_log.push_back(w);
                if (keep_mode == 0 || (keep_mode == 2 && $urandom_range(0, 1) == 0))
                    req[w] = 1'b0;
                else
                    req_data[8*w +: 8] = 8'($urandom);
            end
        end

        if (tx_start) begin
            last_start_cyc = cyc;
            if (first_start_cyc < 0) first_start_cyc = cyc;
            if (exp_q.size() == 0) chk_eq("start_unexpected", 1, 0);
            else chk_eq("tx_data", tx_data, exp_q.pop_front());
            held_data = tx_data;
            if (resp_en) resp_cnt = $urandom_range(0, 8);
        end

        if (timeout_err) begin
            if (expect_to) begin
                chk_eq("to_latency", cyc - last_start_cyc, TIMEOUT);
                chk_eq("to_data_pending", exp_q.size(), 1);
                exp_q.delete();
                to_seen = 1'b1;
            end else begin
                chk_eq("to_unexpected", 1, 0);
            end
        end

        if (rand_on) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic run_idle(input string tag, input int maxc);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(req == 4'd0 && !busy && exp_q.size() == 0 && resp_cnt < 0 && !tx_done) && n < maxc);
        chk_eq(tag, n < maxc, 1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req = 4'd0;
        tx_done = 1'b0;
        resp_cnt = -1;
        exp_q.delete();
        model_rr = 0;
        expect_to = 1'b0;
        repeat (n) cycle();
        chk_eq("rst_ack", ack, 0);
        chk_eq("rst_tx_start", tx_start, 0);
        chk_eq("rst_tx_data", tx_data, 0);
        chk_eq("rst_grant", grant_id, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_timeout", timeout_err, 0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int c0;
        int n;
        int starts;
        int acks;
        int dn;

        reset = 1'b1;
        req = 4'd0;
        req_data = 32'd0;
        tx_done = 1'b0;
        req_n = 4'd0;
        req_data_n = 32'd0;
        tx_done_n = 1'b0;

        do_reset(3);
        chk_eq("rst_nh_busy", busy_n, 0);
        chk_eq("rst_nh_ack", ack_n, 0);

        // Single requester 1: header A1 then 5C, two edges to first tx_start
        req[1] = 1'b1;
        req_data[15:8] = 8'h5C;
        first_start_cyc = -1;
        c0 = cyc;
        run_idle("t1_done", 100);
        chk_eq("t1_latency", first_start_cyc - c0, 2);
        chk_eq("t1_ack", ack_log[ack_log.size()-1], 1);

        // rr_ptr now 2: 4'b0101 serves 2 before 0
        req = 4'b0101;
        req_data = $urandom;
        run_idle("t1_rr_done", 200);
        chk_eq("t1_rr_first", ack_log[ack_log.size()-2], 2);
        chk_eq("t1_rr_second", ack_log[ack_log.size()-1], 0);

        // After reset 4'b0101 serves 0 then 2
        do_reset(2);
        req = 4'b0101;
        req_data = $urandom;
        run_idle("t2_done", 200);
        chk_eq("t2_first", ack_log[ack_log.size()-2], 0);
        chk_eq("t2_second", ack_log[ack_log.size()-1], 2);

        // All four held for 8 transfers
        do_reset(2);
        keep_mode = 1;
        req = 4'hF;
        req_data = $urandom;
        n0 = ack_log.size();
        n = 0;
        while (ack_log.size() - n0 < 8 && n < 3000) begin
            cycle();
            n++;
        end
        req = 4'd0;
        keep_mode = 0;
        chk_eq("t3_bound", n < 3000, 1);
        for (int k = 0; k < 8; k++) begin
            if (n0 + k < ack_log.size()) chk_eq("t3_order", ack_log[n0+k], k % 4);
        end
        run_idle("t3_drain", 200);

        // Header never completes: timeout, data frame dropped
        resp_en = 1'b0;
        expect_to = 1'b1;
        to_seen = 1'b0;
        req[2] = 1'b1;
        req_data[23:16] = 8'h3C;
        n = 0;
        while (!to_seen && n < 700) begin
            cycle();
            n++;
        end
        chk_eq("t4_timeout_seen", to_seen, 1);
        resp_en = 1'b1;
        expect_to = 1'b0;
        repeat (20) cycle();
        chk_eq("t4_idle", busy, 0);
        run_idle("t4_drain", 50);

        // Reset during WAIT_DATA aborts; rr_ptr returns to 0
        do_reset(2);
        req[0] = 1'b1;
        run_idle("t5_pre", 200);
        req[2] = 1'b1;
        n0 = ack_log.size();
        n = 0;
        while (!(ack_log.size() > n0 && exp_q.size() == 0) && n < 200) begin
            cycle();
            n++;
        end
        chk_eq("t5_reach_wait_data", n < 200, 1);
        reset = 1'b1;
        resp_cnt = -1;
        exp_q.delete();
        model_rr = 0;
        cycle();
        chk_eq("t5_tx_start", tx_start, 0);
        chk_eq("t5_busy", busy, 0);
        chk_eq("t5_ack", ack, 0);
        chk_eq("t5_grant", grant_id, 0);
        reset = 1'b0;
        req = 4'b0101;
        req_data = $urandom;
        n0 = ack_log.size();
        run_idle("t5_post", 200);
        if (ack_log.size() >= n0 + 2) begin
            chk_eq("t5_first", ack_log[n0], 0);
            chk_eq("t5_second", ack_log[n0+1], 2);
        end else begin
            chk_eq("t5_ack_count", ack_log.size() - n0, 2);
        end

        // Randomized traffic with spurious tx_done while idle
        do_reset(2);
        n0 = ack_log.size();
        rand_on = 1'b1;
        spur_on = 1'b1;
        keep_mode = 2;
        repeat (3000) cycle();
        rand_on = 1'b0;
        spur_on = 1'b0;
        keep_mode = 0;
        req = 4'd0;
        run_idle("rand_drain", 200);
        chk_eq("rand_progress", ack_log.size() - n0 > 20, 1);

        // Data-only instance: requester 3, byte FF, spurious tx_done while idle
        req_n = 4'b1000;
        req_data_n[31:24] = 8'hFF;
        starts = 0;
        acks = 0;
        dn = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_3125);
            tx_done_n = 1'b0;
            if (dn == 0) begin
                tx_done_n = 1'b1;
                dn = -1;
            end else if (dn > 0) begin
                dn--;
            end
            if (ack_n != 4'd0) begin
                chk_eq("nh_ack", ack_n, 4'b1000);
                chk_eq("nh_grant", grant_id_n, 3);
                req_n = 4'd0;
                acks++;
            end
            if (tx_start_n) begin
                starts++;
                chk_eq("nh_data", tx_data_n, 8'hFF);
                dn = 3;
            end
            if (c == 30) tx_done_n = 1'b1;
        end
        chk_eq("nh_starts", starts, 1);
        chk_eq("nh_acks", acks, 1);
        chk_eq("nh_busy", busy_n, 0);
        chk_eq("nh_timeout", timeout_err_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
